// File: rtl/p_pkg.sv
// -----------------------------------------------------------------------------
// p_pkg
// Shared definitions for the Poly1305 message path: block geometry, the
// formatter FSM state encoding and the layout of the 16-byte length block.
// The tag engine imports the same length-block offsets, so both sides agree
// on where len(AAD) and len(CT) sit inside the final block.
// -----------------------------------------------------------------------------
package p_pkg;

  // Block geometry: one Poly1305 block is 16 bytes, 128 bits.
  localparam int BLK_BYTES = 16;
  localparam int BLK_W     = 8 * BLK_BYTES;
  localparam int BLK_SHIFT = $clog2(BLK_BYTES);

  // Length block: little-endian 64-bit len(AAD) in the low half,
  // 64-bit len(CT) in the high half.
  localparam int LENBLK_FIELD_W = 64;
  localparam int LENBLK_AAD_LSB = 0;
  localparam int LENBLK_CT_LSB  = 64;

  typedef enum logic [2:0] {
    ST_IDLE,   // waiting for i_start
    ST_LOAD,   // fetching block 0 into the buffer
    ST_START,  // presenting block 0 with the tag-engine start pulse
    ST_PREF,   // prefetching the next block into the buffer
    ST_WAITR,  // buffer full, waiting for a block request
    ST_DONE    // every block issued; one cycle before IDLE
  } fmt_state_e;

  // Assemble the trailing length block from the two (zero-extended) lengths.
  function automatic logic [BLK_W-1:0] len_block(
    input logic [LENBLK_FIELD_W-1:0] len_aad,
    input logic [LENBLK_FIELD_W-1:0] len_ct
  );
    logic [BLK_W-1:0] blk;
    blk = '0;
    blk[LENBLK_AAD_LSB +: LENBLK_FIELD_W] = len_aad;
    blk[LENBLK_CT_LSB  +: LENBLK_FIELD_W] = len_ct;
    return blk;
  endfunction

endpackage

// File: rtl/p_pad_mask.sv
// -----------------------------------------------------------------------------
// p_pad_mask
// Byte-enable mask for one 128-bit word of a segment. Inside a segment every
// byte is kept; in the segment's last word only bytes below rem_bytes survive,
// the rest become the zero padding up to the 16-byte boundary.
// Purely combinational.
//
// Ports
//   rem_bytes  in   5    bytes still owed in the segment, clamped to 16
//   is_last    in   1    this word is the last word of the segment
//   mask       out  128  0xFF for kept bytes, 0x00 for padding bytes
// -----------------------------------------------------------------------------
module p_pad_mask
  import p_pkg::*;
(
  input  logic [4:0]       rem_bytes,
  input  logic             is_last,
  output logic [BLK_W-1:0] mask
);

  // NOTE: every output of an always_comb gets a default before any
  // conditional assignment, so no path can leave it unassigned and infer a latch.
  always_comb begin
    mask = '0;
    for (int i = 0; i < BLK_BYTES; i++) begin
      // rem_bytes == 16 on a last word keeps all bytes: no padding needed.
      if (!is_last || (5'(i) < rem_bytes)) begin
        mask[8*i +: 8] = 8'hFF;
      end
    end
  end

endmodule

// File: rtl/p_msg_fmt.sv
// -----------------------------------------------------------------------------
// p_msg_fmt
// Poly1305 message formatter for the RFC 8439 AEAD construction. Takes AAD and
// then ciphertext as 128-bit little-endian words, zero-pads each segment to a
// 16-byte boundary, appends the length block and feeds the tag engine one
// block per request. Block 0 goes out with o_tag_start; every later block goes
// out with o_en_msg, one cycle after the engine's i_rqst_msg. The next block is
// prefetched into a single buffer, and a request that arrives before the
// buffer is full is remembered in a pending flag, so requests are never lost.
//
// Ports
//   i_clk        in   1      clock, rising edge
//   i_rst        in   1      synchronous active-high reset
//   i_start      in   1      begin a message; lengths sampled this cycle
//   i_len_aad    in   LEN_W  AAD length in bytes
//   i_len_ct     in   LEN_W  ciphertext length in bytes
//   i_data       in   128    input word, byte 0 at [7:0]
//   i_data_vld   in   1      i_data valid
//   o_data_rdy   out  1      word accepted when i_data_vld && o_data_rdy
//   i_rqst_msg   in   1      tag engine requests the next block (pulse)
//   o_tag_start  out  1      tag engine start pulse; o_msg holds block 0
//   o_len_msg    out  LEN_W  padded message length in bytes, incl. length block
//   o_msg        out  128    current formatted block
//   o_en_msg     out  1      pulse: o_msg holds the requested block
//   o_busy       out  1      message in progress
// -----------------------------------------------------------------------------
module p_msg_fmt
  import p_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len_aad,
  input  logic [LEN_W-1:0] i_len_ct,
  input  logic [BLK_W-1:0] i_data,
  input  logic             i_data_vld,
  output logic             o_data_rdy,
  input  logic             i_rqst_msg,
  output logic             o_tag_start,
  output logic [LEN_W-1:0] o_len_msg,
  output logic [BLK_W-1:0] o_msg,
  output logic             o_en_msg,
  output logic             o_busy
);

  // Number of 16-byte blocks a segment of len bytes occupies.
  function automatic logic [LEN_W-1:0] n_blocks(input logic [LEN_W-1:0] len);
    return (len + LEN_W'(BLK_BYTES - 1)) >> BLK_SHIFT;
  endfunction

  fmt_state_e       state_q, state_d;
  logic [LEN_W-1:0] len_aad_q, len_ct_q;  // lengths for the length block
  logic [LEN_W-1:0] aad_rem_q, ct_rem_q;  // bytes not yet accepted per segment
  logic [LEN_W-1:0] blk_left_q;           // blocks not yet issued
  logic [BLK_W-1:0] buf_q;                // prefetched block
  logic             pend_q;               // request seen before buffer was full

  logic [LEN_W-1:0] start_blks;
  logic             aad_owed, word_owed;
  logic [LEN_W-1:0] cur_rem;
  logic             is_last;
  logic [4:0]       take;
  logic [BLK_W-1:0] pad_mask;
  logic             fill_slot, fill_now;
  logic [BLK_W-1:0] fill_blk;
  logic             serve;

  // ---------------------------------------------------------------------------
  // Block source: AAD words first, then CT words, then the length block.
  // ---------------------------------------------------------------------------
  assign start_blks = n_blocks(i_len_aad) + n_blocks(i_len_ct) + LEN_W'(1);

  assign aad_owed  = (aad_rem_q != '0);
  assign word_owed = aad_owed || (ct_rem_q != '0);
  assign cur_rem   = aad_owed ? aad_rem_q : ct_rem_q;
  assign is_last   = (cur_rem <= LEN_W'(BLK_BYTES));
  assign take      = is_last ? cur_rem[4:0] : 5'(BLK_BYTES);

  p_pad_mask u_pad_mask (
    .rem_bytes (take),
    .is_last   (is_last),
    .mask      (pad_mask)
  );

  // The buffer can be (re)filled while loading block 0, or while prefetching
  // as long as blocks remain to be issued.
  assign fill_slot  = (state_q == ST_LOAD) ||
                      ((state_q == ST_PREF) && (blk_left_q != '0));
  assign o_data_rdy = fill_slot && word_owed;
  // Once both segments are drained the length block needs no handshake.
  assign fill_now   = fill_slot && (!word_owed || i_data_vld);
  assign fill_blk   = word_owed ? (i_data & pad_mask)
                                : len_block(LENBLK_FIELD_W'(len_aad_q),
                                            LENBLK_FIELD_W'(len_ct_q));

  assign serve  = (state_q == ST_WAITR) && (i_rqst_msg || pend_q);
  assign o_busy = (state_q != ST_IDLE) && (state_q != ST_DONE);

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (i_start) state_d = ST_LOAD;
      ST_LOAD:  if (fill_now) state_d = ST_START;
      ST_START: state_d = ST_PREF;
      ST_PREF: begin
        if (blk_left_q == '0) begin
          state_d = ST_DONE;
        end else if (fill_now) begin
          state_d = ST_WAITR;
        end
      end
      ST_WAITR: if (serve) state_d = ST_PREF;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counters and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      len_aad_q   <= '0;
      len_ct_q    <= '0;
      aad_rem_q   <= '0;
      ct_rem_q    <= '0;
      blk_left_q  <= '0;
      pend_q      <= 1'b0;
      o_tag_start <= 1'b0;
      o_en_msg    <= 1'b0;
      o_msg       <= '0;
      o_len_msg   <= '0;
    end else begin
      state_q     <= state_d;
      o_tag_start <= 1'b0;
      o_en_msg    <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            len_aad_q  <= i_len_aad;
            len_ct_q   <= i_len_ct;
            aad_rem_q  <= i_len_aad;
            ct_rem_q   <= i_len_ct;
            blk_left_q <= start_blks;
            o_len_msg  <= start_blks << BLK_SHIFT;
          end
        end
        ST_START: begin
          o_tag_start <= 1'b1;
          o_msg       <= buf_q;
          blk_left_q  <= blk_left_q - LEN_W'(1);
        end
        ST_WAITR: begin
          if (serve) begin
            o_en_msg   <= 1'b1;
            o_msg      <= buf_q;
            blk_left_q <= blk_left_q - LEN_W'(1);
          end
        end
        default: ;
      endcase

      // Retire the bytes of an accepted data word from its segment.
      if (fill_now && word_owed) begin
        if (aad_owed) begin
          aad_rem_q <= aad_rem_q - LEN_W'(take);
        end else begin
          ct_rem_q <= ct_rem_q - LEN_W'(take);
        end
      end

      // Serving a pending request in WAITR consumes it; a request arriving in
      // that same cycle becomes the next pending one. Outside a message
      // (including after the last block) requests are dropped.
      if (state_q == ST_WAITR) begin
        pend_q <= pend_q && i_rqst_msg;
      end else if (o_busy) begin
        pend_q <= pend_q || i_rqst_msg;
      end else begin
        pend_q <= 1'b0;
      end
    end
  end

  // NOTE: the block buffer is pure datapath and is always written before it is
  // read, so it carries no reset; o_msg, which is observable, is reset instead.
  always_ff @(posedge i_clk) begin
    if (fill_now) begin
      buf_q <= fill_blk;
    end
  end

endmodule
